// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scanner for an HH:MM:SS clock, with colon and alarm blink.
// Define LEADING_ZERO_BLANK_EN to blank the hours tens digit when it is zero.
module seg_scan_driver #(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] H_in1,
   input  logic [3:0] H_in0,
   input  logic [3:0] M_in1,
   input  logic [3:0] M_in0,
   input  logic [3:0] S_in1,
   input  logic [3:0] S_in0,
   input  logic       Alarm,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   logic [15:0] div;
   logic [2:0]  idx;
   logic [7:0]  fcnt;
   logic        ph;
   logic [3:0]  sh_h1, sh_h0, sh_m1, sh_m0, sh_s1, sh_s0;

   logic        div_last;
   logic        frame_wrap;
   logic [3:0]  digit;
   logic [5:0]  an_next;
   logic [6:0]  seg_next;
   logic        dp_next;

   assign div_last   = (div == 16'(SCAN_DIV - 1));
   assign frame_wrap = div_last && (idx == 3'd5);

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   always_comb begin
      digit    = 4'd0;
      an_next  = ~(6'd1 << idx);
      dp_next  = !(((idx == 3'd2) || (idx == 3'd4)) && ph);
      case (idx)
         3'd0:    digit = sh_s0;
         3'd1:    digit = sh_s1;
         3'd2:    digit = sh_m0;
         3'd3:    digit = sh_m1;
         3'd4:    digit = sh_h0;
         3'd5:    digit = sh_h1;
         default: digit = 4'd0;
      endcase
      seg_next = bcd_to_seg(digit);
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx == 3'd5) && (sh_h1 == 4'd0))
         seg_next = 7'b1111111;
`endif
      // Alarm blanks the enables only; seg keeps decoding so the digits reappear cleanly.
      if (Alarm && ph) begin
         an_next = 6'b111111;
         dp_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div   <= 16'd0;
         idx   <= 3'd0;
         fcnt  <= 8'd0;
         ph    <= 1'b0;
         sh_h1 <= 4'd0;
         sh_h0 <= 4'd0;
         sh_m1 <= 4'd0;
         sh_m0 <= 4'd0;
         sh_s1 <= 4'd0;
         sh_s0 <= 4'd0;
         an    <= 6'b111111;
         seg   <= 7'b1111111;
         dp    <= 1'b1;
      end else begin
         if (div_last) begin
            div <= 16'd0;
            idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         end else begin
            div <= div + 16'd1;
         end
         // Shadows load only between frames so a frame never mixes old and new time.
         if (frame_wrap) begin
            sh_h1 <= {2'b00, H_in1};
            sh_h0 <= H_in0;
            sh_m1 <= M_in1;
            sh_m0 <= M_in0;
            sh_s1 <= S_in1;
            sh_s0 <= S_in0;
            if (fcnt == 8'(BLINK_DIV - 1)) begin
               fcnt <= 8'd0;
               ph   <= ~ph;
            end else begin
               fcnt <= fcnt + 8'd1;
            end
         end
         an  <= an_next;
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=2 (24-cycle frame, ph toggles every 48 cycles).
module tb_seg_scan_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] H_in1 = 2'd0;
   logic [3:0] H_in0 = 4'd0, M_in1 = 4'd0, M_in0 = 4'd0, S_in1 = 4'd0, S_in0 = 4'd0;
   logic       Alarm = 1'b0;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int vectors = 0;
   int miscompares = 0;
   int e = 0;
   logic [3:0] exp_sh [6];

   seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
      .clk(clk), .reset(reset),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [5:0] ea, input logic [6:0] es, input logic ed);
      vectors++;
      assert (an === ea && seg === es && dp === ed) else begin
         miscompares++;
         $error("[TB] FAIL %s (cycle %0d): observed an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                tag, e, an, seg, dp, ea, es, ed);
      end
   endtask

   // Edge e after release shows digit ((e-1)/4)%6; shadows seen in a frame were captured on the previous multiple of 24.
   task automatic applyStimulus(input int n, input string tag);
      int         idx;
      logic       ph;
      logic [5:0] ea;
      logic [6:0] es;
      logic       ed;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         e++;
         idx = ((e - 1) / 4) % 6;
         ph  = (((e - 1) / 48) % 2) == 1;
         ea  = ~(6'd1 << idx);
         es  = dec(exp_sh[idx]);
         ed  = !(((idx == 2) || (idx == 4)) && ph);
`ifdef LEADING_ZERO_BLANK_EN
         if (idx == 5 && exp_sh[5] == 4'd0)
            es = 7'b1111111;
`endif
         if (Alarm && ph) begin
            ea = 6'b111111;
            ed = 1'b1;
         end
         checkOutput(tag, ea, es, ed);
         if (e % 24 == 0) begin
            exp_sh[0] = S_in0;
            exp_sh[1] = S_in1;
            exp_sh[2] = M_in0;
            exp_sh[3] = M_in1;
            exp_sh[4] = H_in0;
            exp_sh[5] = {2'b00, H_in1};
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 6; i++) exp_sh[i] = 4'd0;

      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("reset_hold", 6'b111111, 7'b1111111, 1'b1);
      end

      reset = 1'b1;
      e = 0;
      applyStimulus(10, "frame1_zero");
      {H_in1, H_in0, M_in1, M_in0, S_in1, S_in0} = {2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
      applyStimulus(20, "frame1_midframe_update");
      M_in0 = 4'hC;
      applyStimulus(24, "frame2_123456");
      M_in0 = 4'd4;
      H_in1 = 2'd0;
      applyStimulus(42, "frame3_dash_colon");
      Alarm = 1'b1;
      applyStimulus(158, "alarm_blink");

      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_reset", 6'b111111, 7'b1111111, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("mid_reset_hold", 6'b111111, 7'b1111111, 1'b1);

      reset = 1'b1;
      e = 0;
      for (int i = 0; i < 6; i++) exp_sh[i] = 4'd0;
      applyStimulus(30, "restart");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
